// File: rtl/bram_1p_arbiter.sv
// Two-requester arbiter sharing one single-port read-first BRAM, with a burst
// limit so neither side starves. Define BRAM_ARB_CONFLICT_CNT_EN for conflict_cnt_o.
module bram_1p_arbiter #(
  parameter int RAM_WIDTH     = 8,
  parameter int RAM_ADDR_BITS = 10,
  parameter int MAX_BURST     = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     req0_valid_i,
  output logic                     req0_ready_o,
  input  logic [RAM_ADDR_BITS-1:0] req0_addr_i,
  input  logic                     req0_we_i,
  input  logic [RAM_WIDTH-1:0]     req0_data_i,
  input  logic                     req1_valid_i,
  output logic                     req1_ready_o,
  input  logic [RAM_ADDR_BITS-1:0] req1_addr_i,
  input  logic                     req1_we_i,
  input  logic [RAM_WIDTH-1:0]     req1_data_i,
  output logic                     rsp0_valid_o,
  output logic [RAM_WIDTH-1:0]     rsp0_data_o,
  output logic                     rsp1_valid_o,
  output logic [RAM_WIDTH-1:0]     rsp1_data_o,
  output logic                     mem_en_o,
  output logic                     mem_we_o,
  output logic [RAM_ADDR_BITS-1:0] mem_addr_o,
  output logic [RAM_WIDTH-1:0]     mem_data_o,
  input  logic [RAM_WIDTH-1:0]     mem_data_i
`ifdef BRAM_ARB_CONFLICT_CNT_EN
  ,
  output logic [15:0]              conflict_cnt_o
`endif
);

  localparam logic [7:0] MAX_B = 8'(MAX_BURST);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_e;

  state_e     state_q, state_d, gnt_state;
  logic [7:0] burst_cnt_q, burst_cnt_d;
  logic       last_owner_q, last_owner_d;
  logic [1:0] rd_pend_q, rd_pend_d;
  logic       gnt0, gnt1;

  // Grant decision; nothing is granted while reset is asserted.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst_i) begin
      case (state_q)
        IDLE: begin
          if (req0_valid_i && req1_valid_i) begin
            gnt0 = last_owner_q;
            gnt1 = ~last_owner_q;
          end else begin
            gnt0 = req0_valid_i;
            gnt1 = req1_valid_i;
          end
        end
        OWN0: begin
          if (req0_valid_i && (!req1_valid_i || burst_cnt_q < MAX_B)) gnt0 = 1'b1;
          else gnt1 = req1_valid_i;
        end
        OWN1: begin
          if (req1_valid_i && (!req0_valid_i || burst_cnt_q < MAX_B)) gnt1 = 1'b1;
          else gnt0 = req0_valid_i;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d      = state_q;
    burst_cnt_d  = burst_cnt_q;
    last_owner_d = last_owner_q;
    gnt_state    = gnt1 ? OWN1 : OWN0;
    if (gnt0 || gnt1) begin
      state_d      = gnt_state;
      last_owner_d = gnt1;
      if (state_q != gnt_state)    burst_cnt_d = 8'd1;
      else if (burst_cnt_q < MAX_B) burst_cnt_d = burst_cnt_q + 8'd1;
    end else if (!req0_valid_i && !req1_valid_i) begin
      state_d     = IDLE;
      burst_cnt_d = '0;
    end
    rd_pend_d = {gnt1 & ~req1_we_i, gnt0 & ~req0_we_i};
  end

  always_comb begin
    req0_ready_o = gnt0;
    req1_ready_o = gnt1;
    mem_en_o     = gnt0 | gnt1;
    mem_we_o     = 1'b0;
    mem_addr_o   = '0;
    mem_data_o   = '0;
    if (gnt0) begin
      mem_we_o   = req0_we_i;
      mem_addr_o = req0_addr_i;
      mem_data_o = req0_data_i;
    end else if (gnt1) begin
      mem_we_o   = req1_we_i;
      mem_addr_o = req1_addr_i;
      mem_data_o = req1_data_i;
    end
  end

  // A response due in the reset cycle is suppressed rather than delivered.
  always_comb begin
    rsp0_valid_o = rd_pend_q[0] & ~rst_i;
    rsp1_valid_o = rd_pend_q[1] & ~rst_i;
    rsp0_data_o  = rsp0_valid_o ? mem_data_i : '0;
    rsp1_data_o  = rsp1_valid_o ? mem_data_i : '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      burst_cnt_q  <= '0;
      last_owner_q <= 1'b1;
      rd_pend_q    <= '0;
    end else begin
      state_q      <= state_d;
      burst_cnt_q  <= burst_cnt_d;
      last_owner_q <= last_owner_d;
      rd_pend_q    <= rd_pend_d;
    end
  end

`ifdef BRAM_ARB_CONFLICT_CNT_EN
  logic [15:0] conflict_cnt_q, conflict_cnt_d;

  always_comb begin
    conflict_cnt_d = conflict_cnt_q;
    if (req0_valid_i && req1_valid_i && conflict_cnt_q != '1)
      conflict_cnt_d = conflict_cnt_q + 16'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) conflict_cnt_q <= '0;
    else       conflict_cnt_q <= conflict_cnt_d;
  end

  assign conflict_cnt_o = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_bram_1p_arbiter.sv
// Bench for bram_1p_arbiter: directed scenarios then random traffic, compared
// against a grant/run-length model and a shadow memory.
module tb_bram_1p_arbiter;
  localparam int W  = 8;
  localparam int A  = 10;
  localparam int MB = 4;

  logic clk = 1'b0;
  logic rst;
  logic v0, v1, we0, we1;
  logic [A-1:0] a0, a1;
  logic [W-1:0] d0, d1;
  logic r0, r1, rv0, rv1;
  logic [W-1:0] rd0, rd1;
  logic men, mwe;
  logic [A-1:0] maddr;
  logic [W-1:0] mdo, mdi;
`ifdef BRAM_ARB_CONFLICT_CNT_EN
  logic [15:0] ccnt;
`endif

  always #5 clk = ~clk;

  bram_1p_arbiter #(.RAM_WIDTH(W), .RAM_ADDR_BITS(A), .MAX_BURST(MB)) dut (
    .clk_i(clk), .rst_i(rst),
    .req0_valid_i(v0), .req0_ready_o(r0), .req0_addr_i(a0), .req0_we_i(we0), .req0_data_i(d0),
    .req1_valid_i(v1), .req1_ready_o(r1), .req1_addr_i(a1), .req1_we_i(we1), .req1_data_i(d1),
    .rsp0_valid_o(rv0), .rsp0_data_o(rd0), .rsp1_valid_o(rv1), .rsp1_data_o(rd1),
    .mem_en_o(men), .mem_we_o(mwe), .mem_addr_o(maddr), .mem_data_o(mdo), .mem_data_i(mdi)
`ifdef BRAM_ARB_CONFLICT_CNT_EN
    , .conflict_cnt_o(ccnt)
`endif
  );

  // Read-first single-port BRAM with registered output.
  logic [W-1:0] bram [0:(1<<A)-1];
  always @(posedge clk) begin
    if (men) begin
      mdi <= bram[maddr];
      if (mwe) bram[maddr] <= mdo;
    end
  end

  int checks = 0;
  int failures = 0;

  // Reference model: who won last, how long their current run is, whether
  // the previous cycle carried a grant, and which read response is due.
  logic [W-1:0] shadow [0:(1<<A)-1];
  bit   m_busy;
  int   m_last;
  int   m_run;
  int   m_pend;
  logic [W-1:0] m_pend_d;
  int   wait_c [2];
  int   m_ccnt;

  int obs_g;
  logic obs_rv0, obs_rv1;
  logic [W-1:0] obs_rd0, obs_rd1;
  logic [15:0] obs_cc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_grant();
    if (rst) return -1;
    if (!v0 && !v1) return -1;
    if (v0 && !v1) return 0;
    if (v1 && !v0) return 1;
    if (!m_busy) return 1 - m_last;
    if (m_run < MB) return m_last;
    return 1 - m_last;
  endfunction

  task automatic cycle();
    int g;
    logic ewe;
    logic [A-1:0] ea;
    logic [W-1:0] ed;
    @(negedge clk);
    g   = exp_grant();
    ewe = (g == 0) ? we0 : (g == 1) ? we1 : 1'b0;
    ea  = (g == 0) ? a0  : (g == 1) ? a1  : '0;
    ed  = (g == 0) ? d0  : (g == 1) ? d1  : '0;
    chk("ready0", r0, g == 0);
    chk("ready1", r1, g == 1);
    chk("one_ready", r0 & r1, 0);
    chk("mem_en", men, g >= 0);
    chk("mem_we", mwe, ewe);
    chk("mem_addr", maddr, ea);
    chk("mem_data", mdo, ed);
    chk("rsp0_valid", rv0, m_pend == 0 && !rst);
    chk("rsp1_valid", rv1, m_pend == 1 && !rst);
    chk("rsp0_data", rd0, (m_pend == 0 && !rst) ? m_pend_d : '0);
    chk("rsp1_data", rd1, (m_pend == 1 && !rst) ? m_pend_d : '0);
`ifdef BRAM_ARB_CONFLICT_CNT_EN
    chk("conflict_cnt", ccnt, m_ccnt);
    obs_cc = ccnt;
`endif
    // Starvation bound measured from the DUT's own readies.
    if (v0 && !r0 && r1) wait_c[0]++; else if (r0 || !v0 || rst) wait_c[0] = 0;
    if (v1 && !r1 && r0) wait_c[1]++; else if (r1 || !v1 || rst) wait_c[1] = 0;
    chk("fair_wait0", wait_c[0] <= MB, 1);
    chk("fair_wait1", wait_c[1] <= MB, 1);
    obs_g   = r1 ? 1 : (r0 ? 0 : -1);
    obs_rv0 = rv0; obs_rd0 = rd0; obs_rv1 = rv1; obs_rd1 = rd1;

    @(posedge clk);
    if (rst) begin
      m_busy = 0; m_last = 1; m_run = 0; m_pend = -1; m_ccnt = 0;
    end else begin
      if (v0 && v1 && m_ccnt < 16'hFFFF) m_ccnt++;
      m_pend = -1;
      if (g >= 0) begin
        if (m_busy && g == m_last) m_run++; else m_run = 1;
        m_busy = 1;
        m_last = g;
        if (!ewe) begin
          m_pend   = g;
          m_pend_d = shadow[ea];
        end else begin
          shadow[ea] = ed;
        end
      end else if (!v0 && !v1) begin
        m_busy = 0;
        m_run  = 0;
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    v0 = 0; v1 = 0; we0 = 0; we1 = 0; a0 = '0; a1 = '0; d0 = '0; d1 = '0;
  endtask

  int exp_seq [10] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0};

  initial begin
    m_busy = 0; m_last = 1; m_run = 0; m_pend = -1; m_ccnt = 0;
    wait_c[0] = 0; wait_c[1] = 0;
    idle_inputs();
    rst = 1;
    #1;
    cycle();
    cycle();
    chk("reset_ready0", r0, 0);
    chk("reset_mem_en", men, 0);
    rst = 0;

    // Preload addresses 0..15 through port 0 (addr 7 gets 8'h3C).
    for (int i = 0; i < 16; i++) begin
      v0 = 1; we0 = 1; a0 = A'(i); d0 = (i == 7) ? 8'h3C : W'(i * 37 + 5);
      cycle();
    end
    idle_inputs();
    cycle();

    // Single writer: write A5 to 3, read it back.
    v0 = 1; we0 = 1; a0 = 10'd3; d0 = 8'hA5;
    cycle();
    chk("sw_wr_grant", obs_g, 0);
    we0 = 0;
    cycle();
    chk("sw_rd_grant", obs_g, 0);
    idle_inputs();
    cycle();
    chk("sw_rsp_valid", obs_rv0, 1);
    chk("sw_rsp_data", obs_rd0, 8'hA5);

    // Contention: both hold valid for 10 reads from a fresh reset.
    rst = 1;
    cycle();
    rst = 0;
    v0 = 1; v1 = 1; a0 = 10'd3; a1 = 10'd7;
    for (int i = 0; i < 10; i++) begin
      cycle();
      chk($sformatf("contend_grant%0d", i), obs_g, exp_seq[i]);
    end
    idle_inputs();
    cycle();

    // Routing: port 1 reads addr 7 alone.
    v1 = 1; a1 = 10'd7;
    cycle();
    idle_inputs();
    cycle();
    chk("route_rsp1_valid", obs_rv1, 1);
    chk("route_rsp1_data", obs_rd1, 8'h3C);
    chk("route_rsp0_valid", obs_rv0, 0);

    // Reset in the cycle after a granted read drops the response.
    v0 = 1; a0 = 10'd3;
    cycle();
    chk("rstmid_grant", obs_g, 0);
    idle_inputs();
    rst = 1;
    cycle();
    chk("rstmid_rsp0_valid", obs_rv0, 0);
    rst = 0;
    v0 = 1; v1 = 1; a0 = 10'd1; a1 = 10'd2;
    cycle();
    chk("rstmid_port0_wins", obs_g, 0);
    idle_inputs();
    cycle();

`ifdef BRAM_ARB_CONFLICT_CNT_EN
    rst = 1;
    cycle();
    rst = 0;
    v0 = 1; v1 = 1;
    for (int i = 0; i < 5; i++) cycle();
    idle_inputs();
    cycle();
    chk("conflict_five", obs_cc, 16'd5);
    rst = 1;
    cycle();
    rst = 0;
    cycle();
    chk("conflict_cleared", obs_cc, 16'd0);
`endif

    // Random traffic on addresses 0..15.
    for (int i = 0; i < 2000; i++) begin
      rst = ($urandom_range(0, 63) == 0);
      v0  = ($urandom_range(0, 3) != 0);
      v1  = ($urandom_range(0, 3) != 0);
      we0 = $urandom_range(0, 1) == 1;
      we1 = $urandom_range(0, 1) == 1;
      a0  = A'($urandom_range(0, 15));
      a1  = A'($urandom_range(0, 15));
      d0  = W'($urandom);
      d1  = W'($urandom);
      cycle();
    end
    rst = 0;
    idle_inputs();
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
